// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock.
// Returns {remainder, quotient}; divide-by-zero returns zero with no trap.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   div_q, div_d;
  logic                s1_q, s1_d, s2_q, s2_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W:0]     k;
  logic [DATA_W-1:0]   q, r, op1_abs;
  logic                s1_n, s2_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    div_d    = div_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;

    // Trial subtraction; the extra MSB is the borrow that decides restore.
    k       = {1'b0, sr_q[2*DATA_W-1:DATA_W]} - {1'b0, div_q};
    q       = sr_q[DATA_W-1:0];
    r       = sr_q[2*DATA_W:DATA_W+1];
    s1_n    = signed_div_i & opdata1_i[DATA_W-1];
    s2_n    = signed_div_i & opdata2_i[DATA_W-1];
    op1_abs = s1_n ? -opdata1_i : opdata1_i;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            cnt_d   = '0;
            s1_d    = s1_n;
            s2_d    = s2_n;
            div_d   = s2_n ? -opdata2_i : opdata2_i;
            sr_d    = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          end
        end
      end
      BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = END;
      end
      ON: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (cnt_q < CW'(DATA_W)) begin
          if (k[DATA_W]) sr_d = {sr_q[2*DATA_W-1:0], 1'b0};
          else           sr_d = {k[DATA_W-1:0], sr_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Remainder follows the dividend's sign; quotient truncates to zero.
          result_d = {s1_q ? -r : r, (s1_q ^ s2_q) ? -q : q};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        if (!start_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      div_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      div_q    <= div_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table plus annul/reset sequences, scoreboarded results.
module tb_div_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];

  typedef struct {
    bit             sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  div_unit #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) return '0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic run_div(input string tag, input bit sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp, input int hold);
    int lat;
    bit ok;
    logic [2*W-1:0] e;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    // Operands are only sampled once; scramble them to catch re-reads.
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (ready_o) begin lat = n; break; end
    end
    e = exp_q.pop_front();
    if (lat == 0) begin
      chk({tag, "/timeout"}, 0, 1);
    end else begin
      chk({tag, "/latency"}, lat, (b == '0) ? 1 : W + 1);
      chk({tag, "/result"}, result_o, e);
    end
    ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!ready_o || result_o !== e) ok = 1'b0;
    end
    chk({tag, "/hold"}, ok, 1);
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/drop_ready"}, ready_o, 0);
    chk({tag, "/drop_result"}, result_o, 0);
  endtask

  initial begin
    bit ok;
    bit sg;
    logic [W-1:0] ra, rb;

    vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001,  32'hFFFF_FFFD}});
    vecs.push_back('{1'b0, 32'd5,          32'd0,          64'd0});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF}});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE,  32'd14}});
    vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000,  32'd0}});
    vecs.push_back('{1'b1, 32'd0,          32'd5,          64'd0});
    vecs.push_back('{1'b1, 32'hFFFF_FFF0,  32'd0,          64'd0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset/ready", ready_o, 0);
    chk("reset/result", result_o, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i])
      run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp,
              (vecs[i].b == '0) ? 10 : 2);

    for (int i = 0; i < 6; i++) begin
      sg = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      run_div($sformatf("rnd%0d", i), sg, ra, rb, model(sg, ra, rb), 1);
    end

    // Request with annul in IDLE is ignored.
    @(negedge clk); start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    ok = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (ready_o) ok = 1'b0; end
    chk("idle_annul/no_ready", ok, 1);
    @(negedge clk); start_i = 1'b0; annul_i = 1'b0;

    // Annul mid-division at cnt=10.
    @(negedge clk); signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk); annul_i = 1'b0;
    ok = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (ready_o) ok = 1'b0; end
    chk("annul/no_ready", ok, 1);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 2);

    // Reset mid-division at cnt=20.
    @(negedge clk); signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk); rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst/ready", ready_o, 0);
    chk("midrst/result", result_o, 0);
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (ready_o) ok = 1'b0; end
    chk("midrst/no_ready", ok, 1);
    run_div("after_rst", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
